// File: rtl/ps2_key_entry.sv
// ps2_key_entry: PS/2 keyboard receiver (scan code set 2) with hex key entry.
//   clk          - system clock
//   reset        - asynchronous active-low reset
//   ps2_clk      - PS/2 clock from keyboard (asynchronous)
//   ps2_data     - PS/2 data from keyboard (asynchronous)
//   key_valid    - one-cycle pulse per accepted make code
//   key_code     - make code of the last accepted key
//   key_ext      - last accepted key was E0-prefixed
//   key_is_hex   - last accepted key is a hex digit
//   key_hex      - nibble value of the last hex key
//   entry_number - 16-bit shifted hex entry, feeds the display
//   frame_err    - one-cycle pulse on parity, stop or timeout error
module ps2_key_entry #(
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT    = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic        key_valid,
  output logic [7:0]  key_code,
  output logic        key_ext,
  output logic        key_is_hex,
  output logic [3:0]  key_hex,
  output logic [15:0] entry_number,
  output logic        frame_err
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_e;

  logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic          filt_q;
  logic [FW-1:0] filt_cnt_q;
  state_e        state_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic          par_q;
  logic [TW-1:0] tmo_q;
  logic          ext_pend_q, brk_pend_q;
  logic          key_valid_q, key_ext_q, key_is_hex_q, frame_err_q;
  logic [7:0]    key_code_q;
  logic [3:0]    key_hex_q;
  logic [15:0]   entry_q, entry_d;

  logic          filt_flip, fall, tmo_hit, stop_seen, frame_ok, frame_bad;
  logic          hex_hit;
  logic [3:0]    hex_val;

  assign key_valid    = key_valid_q;
  assign key_code     = key_code_q;
  assign key_ext      = key_ext_q;
  assign key_is_hex   = key_is_hex_q;
  assign key_hex      = key_hex_q;
  assign entry_number = entry_q;
  assign frame_err    = frame_err_q;

  always_comb begin
    // The filtered level flips on the FILTER_LEN-th consecutive differing sample.
    filt_flip = (clk_s2_q != filt_q) && (filt_cnt_q == FW'(FILTER_LEN - 1));
    fall      = filt_flip && filt_q;
    // A falling edge in the same cycle wins over the timeout.
    tmo_hit   = (state_q != S_IDLE) && !fall && (tmo_q == TW'(TIMEOUT));
    stop_seen = fall && (state_q == S_STOP);
    frame_ok  = stop_seen && dat_s2_q && (^{shift_q, par_q});
    frame_bad = (stop_seen && !frame_ok) || tmo_hit;

    hex_hit = 1'b1;
    hex_val = 4'h0;
    case (shift_q)
      8'h45: hex_val = 4'h0;
      8'h16: hex_val = 4'h1;
      8'h1E: hex_val = 4'h2;
      8'h26: hex_val = 4'h3;
      8'h25: hex_val = 4'h4;
      8'h2E: hex_val = 4'h5;
      8'h36: hex_val = 4'h6;
      8'h3D: hex_val = 4'h7;
      8'h3E: hex_val = 4'h8;
      8'h46: hex_val = 4'h9;
      8'h1C: hex_val = 4'hA;
      8'h32: hex_val = 4'hB;
      8'h21: hex_val = 4'hC;
      8'h23: hex_val = 4'hD;
      8'h24: hex_val = 4'hE;
      8'h2B: hex_val = 4'hF;
      default: hex_hit = 1'b0;
    endcase

    entry_d = entry_q;
    if (hex_hit)               entry_d = {entry_q[11:0], hex_val};
    else if (shift_q == 8'h66) entry_d = {4'h0, entry_q[15:4]};
    else if (shift_q == 8'h76) entry_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_s1_q     <= 1'b0;
      clk_s2_q     <= 1'b0;
      dat_s1_q     <= 1'b0;
      dat_s2_q     <= 1'b0;
      filt_q       <= 1'b0;
      filt_cnt_q   <= '0;
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      tmo_q        <= '0;
      ext_pend_q   <= 1'b0;
      brk_pend_q   <= 1'b0;
      key_valid_q  <= 1'b0;
      key_code_q   <= '0;
      key_ext_q    <= 1'b0;
      key_is_hex_q <= 1'b0;
      key_hex_q    <= '0;
      entry_q      <= '0;
      frame_err_q  <= 1'b0;
    end else begin
      clk_s1_q <= ps2_clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_data;
      dat_s2_q <= dat_s1_q;

      if (clk_s2_q == filt_q) begin
        filt_cnt_q <= '0;
      end else if (filt_flip) begin
        filt_q     <= clk_s2_q;
        filt_cnt_q <= '0;
      end else begin
        filt_cnt_q <= filt_cnt_q + FW'(1);
      end

      if (state_q == S_IDLE || fall)  tmo_q <= '0;
      else if (tmo_q != TW'(TIMEOUT)) tmo_q <= tmo_q + TW'(1);

      if (tmo_hit) begin
        state_q <= S_IDLE;
      end else if (fall) begin
        case (state_q)
          S_IDLE: if (!dat_s2_q) begin
            state_q   <= S_DATA;
            bit_cnt_q <= '0;
          end
          S_DATA: begin
            shift_q   <= {dat_s2_q, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= S_PARITY;
          end
          S_PARITY: begin
            par_q   <= dat_s2_q;
            state_q <= S_STOP;
          end
          default: state_q <= S_IDLE;
        endcase
      end

      // Scan layer sees the completed byte in the stop-edge cycle, so its
      // registered outputs appear one cycle later.
      key_valid_q <= 1'b0;
      frame_err_q <= frame_bad;
      if (frame_ok) begin
        if (shift_q == 8'hE0) begin
          ext_pend_q <= 1'b1;
        end else if (shift_q == 8'hF0) begin
          brk_pend_q <= 1'b1;
        end else if (brk_pend_q) begin
          brk_pend_q <= 1'b0;
          ext_pend_q <= 1'b0;
        end else begin
          key_valid_q <= 1'b1;
          key_code_q  <= shift_q;
          key_ext_q   <= ext_pend_q;
          ext_pend_q  <= 1'b0;
          if (ext_pend_q) begin
            key_is_hex_q <= 1'b0;
          end else begin
            key_is_hex_q <= hex_hit;
            if (hex_hit) key_hex_q <= hex_val;
            entry_q <= entry_d;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_entry.sv
module tb_ps2_key_entry;

  localparam int unsigned FLEN = 8;
  localparam int unsigned TMO  = 1000;
  localparam int unsigned HALF = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic        key_valid, key_ext, key_is_hex, frame_err;
  logic [7:0]  key_code;
  logic [3:0]  key_hex;
  logic [15:0] entry_number;

  ps2_key_entry #(.FILTER_LEN(FLEN), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key_valid(key_valid), .key_code(key_code), .key_ext(key_ext),
    .key_is_hex(key_is_hex), .key_hex(key_hex), .entry_number(entry_number),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  code;
    logic        bad_par;
    logic        bad_stop;
    int unsigned kv;
    int unsigned fe;
    logic [7:0]  e_code;
    logic        e_ext;
    logic        e_is_hex;
    logic [3:0]  e_hex;
    logic [15:0] e_entry;
  } vec_t;

  vec_t tbl [16];

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Pulse monitor
  int unsigned kv_cnt = 0, fe_cnt = 0, kv_wide = 0, fe_wide = 0, both = 0;
  logic prev_kv = 1'b0, prev_fe = 1'b0;
  always @(negedge clk) begin
    if (key_valid) kv_cnt++;
    if (frame_err) fe_cnt++;
    if (key_valid && prev_kv) kv_wide++;
    if (frame_err && prev_fe) fe_wide++;
    if (key_valid && frame_err) both++;
    prev_kv = key_valid;
    prev_fe = frame_err;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bits(input logic [10:0] bits, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      ps2_data = bits[i];
      repeat (HALF) @(posedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(posedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic bp, input logic bs);
    logic par;
    par = ~(^b) ^ bp;
    return {~bs, par, b, 1'b0};
  endfunction

  task automatic apply_vec(input vec_t v, input int unsigned idx);
    int unsigned kv0, fe0;
    kv0 = kv_cnt;
    fe0 = fe_cnt;
    send_bits(mk_frame(v.code, v.bad_par, v.bad_stop), 11);
    repeat (2 * HALF) @(posedge clk);
    @(negedge clk);
    chk($sformatf("v%0d key_valid_pulses", idx), kv_cnt - kv0, v.kv);
    chk($sformatf("v%0d frame_err_pulses", idx), fe_cnt - fe0, v.fe);
    chk($sformatf("v%0d key_code", idx), 32'(key_code), 32'(v.e_code));
    chk($sformatf("v%0d key_ext", idx), 32'(key_ext), 32'(v.e_ext));
    chk($sformatf("v%0d key_is_hex", idx), 32'(key_is_hex), 32'(v.e_is_hex));
    chk($sformatf("v%0d key_hex", idx), 32'(key_hex), 32'(v.e_hex));
    chk($sformatf("v%0d entry_number", idx), 32'(entry_number), 32'(v.e_entry));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " key_valid"}, 32'(key_valid), 0);
    chk({tag, " key_code"}, 32'(key_code), 0);
    chk({tag, " key_ext"}, 32'(key_ext), 0);
    chk({tag, " key_is_hex"}, 32'(key_is_hex), 0);
    chk({tag, " key_hex"}, 32'(key_hex), 0);
    chk({tag, " entry_number"}, 32'(entry_number), 0);
    chk({tag, " frame_err"}, 32'(frame_err), 0);
  endtask

  initial begin
    int unsigned kv0, fe0;
    //            code  bp    bs    kv fe e_code ext   hex?  hex    entry
    tbl[0]  = '{8'h16, 1'b0, 1'b0, 1, 0, 8'h16, 1'b0, 1'b1, 4'h1, 16'h0001};
    tbl[1]  = '{8'h1E, 1'b0, 1'b0, 1, 0, 8'h1E, 1'b0, 1'b1, 4'h2, 16'h0012};
    tbl[2]  = '{8'h26, 1'b0, 1'b0, 1, 0, 8'h26, 1'b0, 1'b1, 4'h3, 16'h0123};
    tbl[3]  = '{8'h25, 1'b0, 1'b0, 1, 0, 8'h25, 1'b0, 1'b1, 4'h4, 16'h1234};
    tbl[4]  = '{8'h2E, 1'b0, 1'b0, 1, 0, 8'h2E, 1'b0, 1'b1, 4'h5, 16'h2345};
    tbl[5]  = '{8'hF0, 1'b0, 1'b0, 0, 0, 8'h2E, 1'b0, 1'b1, 4'h5, 16'h2345};
    tbl[6]  = '{8'h16, 1'b0, 1'b0, 0, 0, 8'h2E, 1'b0, 1'b1, 4'h5, 16'h2345};
    tbl[7]  = '{8'h66, 1'b0, 1'b0, 1, 0, 8'h66, 1'b0, 1'b0, 4'h5, 16'h0234};
    tbl[8]  = '{8'h76, 1'b0, 1'b0, 1, 0, 8'h76, 1'b0, 1'b0, 4'h5, 16'h0000};
    tbl[9]  = '{8'h45, 1'b1, 1'b0, 0, 1, 8'h76, 1'b0, 1'b0, 4'h5, 16'h0000};
    tbl[10] = '{8'h45, 1'b0, 1'b1, 0, 1, 8'h76, 1'b0, 1'b0, 4'h5, 16'h0000};
    tbl[11] = '{8'h45, 1'b0, 1'b0, 1, 0, 8'h45, 1'b0, 1'b1, 4'h0, 16'h0000};
    tbl[12] = '{8'h1C, 1'b0, 1'b0, 1, 0, 8'h1C, 1'b0, 1'b1, 4'hA, 16'h000A};
    tbl[13] = '{8'hE0, 1'b0, 1'b0, 0, 0, 8'h1C, 1'b0, 1'b1, 4'hA, 16'h000A};
    tbl[14] = '{8'h1C, 1'b0, 1'b0, 1, 0, 8'h1C, 1'b1, 1'b0, 4'hA, 16'h000A};
    tbl[15] = '{8'h1E, 1'b0, 1'b0, 1, 0, 8'h1E, 1'b0, 1'b1, 4'h2, 16'h0002};

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b1;
    repeat (40) @(posedge clk);

    for (int unsigned i = 0; i < 12; i++) apply_vec(tbl[i], i);

    // Partial frame then silence: one timeout error, receiver back in IDLE.
    kv0 = kv_cnt;
    fe0 = fe_cnt;
    send_bits(mk_frame(8'h3C, 1'b0, 1'b0), 5);
    repeat (TMO + 10) @(posedge clk);
    @(negedge clk);
    chk("timeout frame_err_pulses", fe_cnt - fe0, 1);
    chk("timeout key_valid_pulses", kv_cnt - kv0, 0);
    apply_vec(tbl[12], 12);

    // Short low glitch with data low: must not start a frame.
    kv0 = kv_cnt;
    fe0 = fe_cnt;
    ps2_data = 1'b0;
    @(posedge clk);
    ps2_clk = 1'b0;
    repeat (FLEN - 2) @(posedge clk);
    ps2_clk = 1'b1;
    repeat (4) @(posedge clk);
    ps2_data = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("glitch frame_err_pulses", fe_cnt - fe0, 0);
    chk("glitch key_valid_pulses", kv_cnt - kv0, 0);
    apply_vec(tbl[13], 13);
    apply_vec(tbl[14], 14);

    // Reset mid-frame, checked before any clock edge to catch a synchronous reset.
    send_bits(mk_frame(8'h45, 1'b0, 1'b0), 4);
    @(posedge clk);
    #2 reset = 1'b0;
    #1 chk_all_zero("midframe_reset");
    repeat (3) @(posedge clk);
    reset = 1'b1;
    repeat (40) @(posedge clk);
    apply_vec(tbl[15], 15);

    chk("key_valid_width", kv_wide, 0);
    chk("frame_err_width", fe_wide, 0);
    chk("kv_fe_overlap", both, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ps2_key_entry.md
Name: ps2_key_entry

Overview:
- Input-side counterpart of the 7-segment display driver.
- Receives PS/2 keyboard frames (scan code set 2) and decodes make/break sequences.
- Maps hex keys to nibbles and shifts them into a 16-bit entry register that feeds the display's displayed_number.
- Also exposes raw key events for the calculator control logic.

Parameters:
- FILTER_LEN, 8: consecutive identical samples required before the filtered ps2_clk level changes.
- TIMEOUT, 50000: clk cycles without a ps2_clk falling edge before a partial frame is aborted.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- ps2_clk  in  1  PS/2 clock from keyboard (asynchronous)
- ps2_data  in  1  PS/2 data from keyboard (asynchronous)
- key_valid  out  1  one-cycle pulse on each accepted make code
- key_code  out  8  make code of the last accepted key
- key_ext  out  1  last accepted key was E0-prefixed
- key_is_hex  out  1  last accepted key is a hex digit
- key_hex  out  4  nibble value of the last hex key
- entry_number  out  16  accumulated hex entry, to the display
- frame_err  out  1  one-cycle pulse on a parity, stop or timeout error

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0; FSM in IDLE; flags, bit counter, filter and timeout counter cleared. Reset asserted mid-frame discards the partial frame.
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-FF synchroniser.
  - The filtered ps2_clk level changes only after FILTER_LEN consecutive equal synchronised samples.
  - A falling edge is the filtered level going 1->0; each falling edge samples the synchronised ps2_data.
- Frame FSM:
  - IDLE -> DATA on a falling edge with data=0 (start bit). A start sample of 1 is ignored and the FSM stays in IDLE with no error.
  - DATA: 8 bits, LSB first, then -> PARITY.
  - PARITY: captures the parity bit, then -> STOP.
  - STOP: on the falling edge, the frame is good if the stop bit = 1 and the count of ones across the 8 data bits plus parity is odd. Good -> byte accepted; otherwise frame_err pulses. Both cases return to IDLE.
- Timeout: the counter resets on every falling edge and counts in every state except IDLE. When it reaches TIMEOUT, the FSM returns to IDLE and frame_err pulses for 1 cycle.
- Timing: the byte is accepted on the cycle the stop falling edge is detected (cycle N). The scan layer acts in cycle N+1: key_valid and frame_err are registered, and entry_number updates in the same cycle N+1.
- Scan layer, per accepted byte:
  - 0xE0: sets ext_pending; no event.
  - 0xF0: sets brk_pending; no event.
  - Any other byte with brk_pending=1: clears both pending flags; no event; entry_number unchanged (break codes are swallowed).
  - Any other byte with brk_pending=0: key_valid=1, key_code=byte, key_ext=ext_pending; ext_pending cleared.
- Hex map (applies only when not extended):
  - 0=45, 1=16, 2=1E, 3=26, 4=25, 5=2E, 6=36, 7=3D, 8=3E, 9=46
  - A=1C, B=32, C=21, D=23, E=24, F=2B
  - Hit: key_is_hex=1, key_hex=value, entry_number <= {entry_number[11:0], value}. The oldest nibble drops off with no saturation or flag.
  - Miss: key_is_hex=0; key_hex holds its previous value.
- Edit keys (non-extended; each still pulses key_valid):
  - 0x66 (backspace): entry_number <= {4'h0, entry_number[15:4]}.
  - 0x76 (escape): entry_number <= 0.
- key_code, key_ext, key_is_hex and key_hex hold their values until the next key_valid.
- frame_err and key_valid are never asserted in the same cycle.

Test Plan:
- Reset, then a good frame 0x16 (parity 0) -> key_valid for exactly 1 cycle, key_code=16, key_is_hex=1, key_hex=1, entry_number=0x0001.
- Make codes 16,1E,26,25,2E (keys 1-5) -> entry_number reads 0001, 0012, 0123, 1234, then 2345.
- With entry=0x2345, send F0 16 -> no key_valid, entry unchanged. Then 66 -> 0x0234. Then 76 -> 0x0000.
- Frame 0x45 with bad parity, then 0x45 with stop=0 -> frame_err once per frame, no key_valid, entry unchanged. A following good 0x45 -> key_hex=0.
- 5 bits of a frame, then ps2_clk held high for TIMEOUT+10 cycles -> single frame_err pulse, FSM in IDLE. Next good 0x1C -> key_hex=A.
- ps2_clk glitch low for FILTER_LEN-2 cycles while idle -> no state change. E0 1C -> key_valid, key_ext=1, key_is_hex=0, entry unchanged. Reset asserted mid-frame -> all outputs 0, next frame decodes correctly.
